// File: rtl/keccak_msg_packer.sv
// keccak_msg_packer: packs a byte stream big-endian into 64-bit keccak input words
module keccak_msg_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    input  logic        s_keep,
    output logic        s_ready,
    input  logic        msg_start,
    output logic [63:0] in,
    output logic        in_ready,
    output logic        is_last,
    output logic [2:0]  byte_num,
    input  logic        buffer_full,
    output logic        msg_done
);
    typedef enum logic [1:0] {FILL, FULL, LAST, DONE} state_t;
    state_t state, state_n;
    logic [63:0] word;
    logic [2:0] cnt;
    logic pend_last;
    logic accept, xfer, data_beat;
    assign s_ready   = state == FILL;
    assign in_ready  = state == FULL || state == LAST;
    assign is_last   = state == LAST;
    assign byte_num  = is_last ? cnt : 3'd0;
    assign in        = word;
    assign msg_done  = state == DONE;
    assign accept    = s_valid && s_ready;
    assign xfer      = in_ready && !buffer_full;
    assign data_beat = !s_last || s_keep;
    always_comb begin
        state_n = state;
        case (state)
            FILL:    state_n = !accept ? FILL : !data_beat ? LAST : cnt == 3'd7 ? FULL : s_last ? LAST : FILL;
            FULL:    state_n = !xfer ? FULL : pend_last ? LAST : FILL;
            LAST:    state_n = xfer ? DONE : LAST;
            default: state_n = msg_start ? FILL : DONE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FILL;
        else state <= state_n;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word      <= 64'd0;
            cnt       <= 3'd0;
            pend_last <= 1'b0;
        end else if (accept && data_beat) begin
            word[{~cnt, 3'b111} -: 8] <= s_data;
            if (cnt == 3'd7) pend_last <= s_last;
            else cnt <= cnt + 3'd1;
        end else if (xfer) begin
            word <= 64'd0;
            cnt  <= 3'd0;
            if (state == FULL) pend_last <= 1'b0;
        end
    end
endmodule

// File: tb/tb_keccak_msg_packer.sv
// tb_keccak_msg_packer: directed stimulus with a queue scoreboard checking every word transfer
module tb_keccak_msg_packer;
    logic        clk = 0;
    logic        reset = 1;
    logic [7:0]  s_data = 0;
    logic        s_valid = 0, s_last = 0, s_keep = 0;
    logic        s_ready;
    logic        msg_start = 0;
    logic [63:0] in;
    logic        in_ready, is_last;
    logic [2:0]  byte_num;
    logic        buffer_full = 0;
    logic        msg_done;
    keccak_msg_packer dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_keep(s_keep), .s_ready(s_ready), .msg_start(msg_start), .in(in),
        .in_ready(in_ready), .is_last(is_last), .byte_num(byte_num),
        .buffer_full(buffer_full), .msg_done(msg_done)
    );
    always #5 clk = ~clk;
    typedef struct packed { logic [63:0] w; logic l; logic [2:0] n; } exp_t;
    exp_t sb[$];
    int d_checks = 0, d_errs = 0, m_checks = 0, m_errs = 0, xfers = 0;
    logic chk_done = 0;
    always @(negedge clk) begin
        exp_t e;
        if (chk_done) begin
            m_checks++;
            if (msg_done !== 1'b1) begin
                m_errs++;
                $display("FAIL done_after_last got %b want 1", msg_done);
            end
            chk_done = 0;
        end
        if (!reset && in_ready && !buffer_full) begin
            xfers++;
            m_checks++;
            if (sb.size() == 0) begin
                m_errs++;
                $display("FAIL unexpected_xfer got %h last %b n %0d want none", in, is_last, byte_num);
            end else begin
                e = sb.pop_front();
                if ({in, is_last, byte_num} !== e) begin
                    m_errs++;
                    $display("FAIL xfer got %h last %b n %0d want %h last %b n %0d", in, is_last, byte_num, e.w, e.l, e.n);
                end
            end
            if (is_last) chk_done = 1;
        end
    end
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        d_checks++;
        if (got !== want) begin
            d_errs++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask
    task automatic send(input logic [7:0] d, input logic l, input logic k);
        int n = 0;
        s_valid = 1; s_data = d; s_last = l; s_keep = k;
        while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!s_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 0; s_last = 0; s_keep = 0;
    endtask
    task automatic wait_done();
        int n = 0;
        while (!msg_done && n < 200) begin @(posedge clk); #1; n++; end
        chk("msg_done", {63'd0, msg_done}, 1);
    endtask
    task automatic restart();
        msg_start = 1;
        @(posedge clk); #1;
        msg_start = 0;
        chk("restart_s_ready", {63'd0, s_ready}, 1);
        chk("restart_msg_done", {63'd0, msg_done}, 0);
    endtask
    task automatic chk_reset_outs();
        chk("rst_in", in, 0);
        chk("rst_flags", {58'd0, in_ready, is_last, byte_num, msg_done, s_ready}, 64'd1);
    endtask
    initial begin
        string s = "The quick brown fox jumps over the lazy dog";
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs();
        reset = 0;
        sb.push_back({64'h5468652071756963, 1'b0, 3'd0});
        sb.push_back({64'h6B2062726F776E20, 1'b0, 3'd0});
        sb.push_back({64'h666F78206A756D70, 1'b0, 3'd0});
        sb.push_back({64'h73206F7665722074, 1'b0, 3'd0});
        sb.push_back({64'h6865206C617A7920, 1'b0, 3'd0});
        sb.push_back({64'h646F670000000000, 1'b1, 3'd3});
        for (int i = 0; i < 43; i++) send(s[i], i == 42, 1'b1);
        wait_done();
        restart();
        sb.push_back({64'h0, 1'b1, 3'd0});
        send(8'h00, 1'b1, 1'b0);
        wait_done();
        restart();
        sb.push_back({64'h1234567890ABCDEF, 1'b0, 3'd0});
        sb.push_back({64'h0, 1'b1, 3'd0});
        send(8'h12, 0, 1); send(8'h34, 0, 1); send(8'h56, 0, 1); send(8'h78, 0, 1);
        send(8'h90, 0, 1); send(8'hAB, 0, 1); send(8'hCD, 0, 1); send(8'hEF, 1, 1);
        wait_done();
        s_valid = 1; s_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("done_hold", {62'd0, s_ready, in_ready}, 0);
        end
        s_valid = 0;
        restart();
        sb.push_back({64'h0102030405060708, 1'b0, 3'd0});
        sb.push_back({64'h9900000000000000, 1'b1, 3'd1});
        buffer_full = 1;
        for (int i = 1; i <= 8; i++) send(8'(i), 0, 1);
        s_valid = 1; s_data = 8'h99; s_last = 1; s_keep = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_word", in, 64'h0102030405060708);
            chk("bp_flags", {61'd0, in_ready, s_ready, is_last}, 64'b100);
        end
        buffer_full = 0;
        @(posedge clk); #1;
        chk("bp_release_s_ready", {63'd0, s_ready}, 1);
        @(posedge clk); #1;
        s_valid = 0; s_last = 0; s_keep = 0;
        chk("bp_byte", {56'd0, in[63:56]}, 64'h99);
        wait_done();
        restart();
        send(8'h11, 0, 1); send(8'h22, 0, 1); send(8'h33, 0, 1);
        reset = 1;
        #1;
        chk_reset_outs();
        @(posedge clk); #1;
        reset = 0;
        sb.push_back({64'hA100000000000000, 1'b1, 3'd1});
        send(8'hA1, 1, 1);
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 0);
        chk("xfer_count", 64'(xfers), 12);
        $display("CHECKS %0d ERRORS %0d", d_checks + m_checks, d_errs + m_errs);
        $finish;
    end
endmodule
